// File: rtl/alu_ext_arb_if.sv
// ============================================================================
// Module   : alu_ext_arb_if
// Brief    : Requester-side and unit-side bundle for the alu_ext arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LEN_FUNC3
`define LEN_FUNC3 3
`endif
`ifndef LEN_FUNC7
`define LEN_FUNC7 7
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif

interface alu_ext_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]                  req_order;
  logic [NUM_REQ*`LEN_FUNC3-1:0]       req_func3;
  logic [NUM_REQ*`LEN_FUNC7-1:0]       req_func7;
  logic [NUM_REQ*`LEN_WORD-1:0]        req_rs1;
  logic [NUM_REQ*`LEN_WORD-1:0]        req_rs2;
  logic [NUM_REQ*`LEN_PREG_ADDR-1:0]   req_pa_rd;
  logic [NUM_REQ-1:0]                  req_accepted;
  logic [NUM_REQ-1:0]                  req_done;
  logic [`LEN_WORD-1:0]                res_rd;
  logic [`LEN_PREG_ADDR-1:0]           res_pa_rd;
  logic                                u_order;
  logic                                u_accepted;
  logic                                u_done;
  logic [`LEN_FUNC3-1:0]               u_func3;
  logic [`LEN_FUNC7-1:0]               u_func7;
  logic [`LEN_WORD-1:0]                u_rs1;
  logic [`LEN_WORD-1:0]                u_rs2;
  logic [`LEN_WORD-1:0]                u_rd;
  logic                                err_spurious;

  // Arbiter view
  modport slave (
    input  req_order, req_func3, req_func7, req_rs1, req_rs2, req_pa_rd,
    input  u_accepted, u_done, u_rd,
    output req_accepted, req_done, res_rd, res_pa_rd,
    output u_order, u_func3, u_func7, u_rs1, u_rs2, err_spurious
  );

  // Requesters plus alu_ext view
  modport master (
    output req_order, req_func3, req_func7, req_rs1, req_rs2, req_pa_rd,
    output u_accepted, u_done, u_rd,
    input  req_accepted, req_done, res_rd, res_pa_rd,
    input  u_order, u_func3, u_func7, u_rs1, u_rs2, err_spurious
  );
endinterface

`default_nettype wire

// File: rtl/alu_ext_arb.sv
// ============================================================================
// Module   : alu_ext_arb
// Brief    : Shares one alu_ext unit among NUM_REQ requesters, one op in flight.
//            ALU_EXT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LEN_FUNC3
`define LEN_FUNC3 3
`endif
`ifndef LEN_FUNC7
`define LEN_FUNC7 7
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif

module alu_ext_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_ext_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LF3   = `LEN_FUNC3;
  localparam int LF7   = `LEN_FUNC7;
  localparam int LW    = `LEN_WORD;
  localparam int LT    = `LEN_PREG_ADDR;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [LF3-1:0]      f3_q;
  logic [LF7-1:0]      f7_q;
  logic [LW-1:0]       rs1_q;
  logic [LW-1:0]       rs2_q;
  logic [LT-1:0]       tag_q;
  logic [LW-1:0]       res_rd_q;
  logic [LT-1:0]       res_tag_q;
  logic [NUM_REQ-1:0]  req_done_q;
  logic                u_order_q;
  logic                err_q;

  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;

`ifdef ALU_EXT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_order[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q;

  // Walk offsets from the highest down so the smallest offset from ptr wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] r;
    int             cand;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (req[cand[IDX_W-1:0]]) r = {1'b1, cand[IDX_W-1:0]};
    end
    return r;
  endfunction

  always_comb begin
    {gnt_vld, gnt_idx} = rr_pick(bus.req_order, ptr_q);
  end
`endif

  // Gated by rst so a held order cannot produce an accept pulse in reset.
  assign bus.req_accepted = (state_q == S_IDLE && gnt_vld && !rst) ? (ONE << gnt_idx) : '0;
  assign bus.req_done     = req_done_q;
  assign bus.res_rd       = res_rd_q;
  assign bus.res_pa_rd    = res_tag_q;
  assign bus.u_order      = u_order_q;
  assign bus.u_func3      = f3_q;
  assign bus.u_func7      = f7_q;
  assign bus.u_rs1        = rs1_q;
  assign bus.u_rs2        = rs2_q;
  assign bus.err_spurious = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      tag_q      <= '0;
      res_rd_q   <= '0;
      res_tag_q  <= '0;
      req_done_q <= '0;
      u_order_q  <= 1'b0;
      err_q      <= 1'b0;
`ifndef ALU_EXT_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      req_done_q <= '0;
      if (bus.u_done && (state_q == S_IDLE || state_q == S_DONE)) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            gnt_q     <= gnt_idx;
            f3_q      <= bus.req_func3[gnt_idx*LF3 +: LF3];
            f7_q      <= bus.req_func7[gnt_idx*LF7 +: LF7];
            rs1_q     <= bus.req_rs1[gnt_idx*LW +: LW];
            rs2_q     <= bus.req_rs2[gnt_idx*LW +: LW];
            tag_q     <= bus.req_pa_rd[gnt_idx*LT +: LT];
            u_order_q <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.u_accepted) begin
            u_order_q <= 1'b0;
            if (bus.u_done) begin
              res_rd_q   <= bus.u_rd;
              res_tag_q  <= tag_q;
              req_done_q <= ONE << gnt_q;
              state_q    <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.u_done) begin
            res_rd_q   <= bus.u_rd;
            res_tag_q  <= tag_q;
            req_done_q <= ONE << gnt_q;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
`ifndef ALU_EXT_ARB_FIXED_PRIO_EN
          ptr_q <= (int'(gnt_q) + 1 == NUM_REQ) ? '0 : gnt_q + 1'b1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_alu_ext_arb.sv
// ============================================================================
// Module   : tb_alu_ext_arb
// Brief    : Randomized self-checking bench; the bench plays requesters and alu_ext.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ext_arb;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ext_arb_if #(.NUM_REQ(N)) bus ();
  alu_ext_arb #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Requester intent
  bit          want [N];
  logic [2:0]  pf3  [N];
  logic [6:0]  pf7  [N];
  logic [31:0] prs1 [N];
  logic [31:0] prs2 [N];
  logic [5:0]  ptag [N];

  // Reference model
  int          cyc = 0;
  bit          m_busy, m_issue, m_err;
  int          m_ptr, m_g, m_done_cyc;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [31:0] m_rs1, m_rs2, m_res, m_last_res;
  logic [5:0]  m_tag, m_last_tag;
  int          u_bp, u_lat, u_cnt;
  int          force_bp = -1, force_lat = -1;
  bit          spur_req;
  int          grant_log[$];
  int          act_acc_cyc, act_done_cyc;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] unit_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    case (f3)
      3'd4, 3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6, 3'd7: return (b == 0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic int exp_grant();
`ifdef ALU_EXT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (want[i]) return i;
`else
    for (int i = 0; i < N; i++) if (want[(m_ptr + i) % N]) return (m_ptr + i) % N;
`endif
    return -1;
  endfunction

  function automatic bit want_any();
    for (int i = 0; i < N; i++) if (want[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    want[i] = 1'b1; pf3[i] = f3; pf7[i] = f7; prs1[i] = a; prs2[i] = b; ptag[i] = tag;
  endtask

  task automatic model_reset();
    m_busy = 0; m_issue = 0; m_err = 0; m_ptr = 0; m_done_cyc = -1;
    m_last_res = '0; m_last_tag = '0; u_cnt = 0; u_bp = 0; spur_req = 0;
    for (int i = 0; i < N; i++) want[i] = 0;
  endtask

  task automatic step();
    int g;
    bit acc_now, done_now, spur_now, exp_done;
    @(negedge clk);
    acc_now = 0; done_now = 0; spur_now = 0;
    for (int i = 0; i < N; i++) begin
      bus.req_order[i]        = want[i];
      bus.req_func3[i*3 +: 3] = pf3[i];
      bus.req_func7[i*7 +: 7] = pf7[i];
      bus.req_rs1[i*32 +: 32] = prs1[i];
      bus.req_rs2[i*32 +: 32] = prs2[i];
      bus.req_pa_rd[i*6 +: 6] = ptag[i];
    end
    bus.u_accepted = 1'b0;
    bus.u_done     = 1'b0;
    bus.u_rd       = $urandom;
    if (m_busy && u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin bus.u_done = 1'b1; bus.u_rd = m_res; done_now = 1; end
    end else if (m_busy && m_issue) begin
      if (u_bp > 0) u_bp--;
      else begin
        bus.u_accepted = 1'b1; acc_now = 1;
        if (u_lat == 0) begin bus.u_done = 1'b1; bus.u_rd = m_res; done_now = 1; end
        else u_cnt = u_lat;
      end
    end
    if (spur_req && !m_busy) begin bus.u_done = 1'b1; spur_now = 1; spur_req = 0; end
    #1;
    g = m_busy ? -1 : exp_grant();
    exp_done = m_busy && (cyc == m_done_cyc);
    check("req_accepted", bus.req_accepted, (g >= 0) ? (1 << g) : 0);
    check("req_done", bus.req_done, exp_done ? (1 << m_g) : 0);
    check("res_rd", bus.res_rd, exp_done ? m_res : m_last_res);
    check("res_pa_rd", bus.res_pa_rd, exp_done ? m_tag : m_last_tag);
    check("u_order", bus.u_order, m_issue);
    if (m_issue)
      check("u_operands", {bus.u_func3, bus.u_func7, bus.u_rs1, bus.u_rs2},
            {m_f3, m_f7, m_rs1, m_rs2});
    check("err_spurious", bus.err_spurious, m_err);
    if (bus.req_accepted != 0) act_acc_cyc = cyc;
    if (bus.req_done != 0) act_done_cyc = cyc;
    if (spur_now) m_err = 1;
    if (exp_done) begin
      m_busy = 0; m_ptr = (m_g + 1) % N; m_last_res = m_res; m_last_tag = m_tag;
    end
    if (acc_now) m_issue = 0;
    if (done_now) m_done_cyc = cyc + 1;
    if (g >= 0) begin
      m_busy = 1; m_issue = 1; m_g = g; want[g] = 0; grant_log.push_back(g);
      m_f3 = pf3[g]; m_f7 = pf7[g]; m_rs1 = prs1[g]; m_rs2 = prs2[g]; m_tag = ptag[g];
      m_res = unit_result(m_f3, m_rs1, m_rs2);
      u_bp  = (force_bp >= 0) ? force_bp : int'($urandom_range(0, 2));
      u_lat = (m_f3 < 4) ? 0 : ((force_lat >= 0) ? force_lat : int'($urandom_range(1, 4)));
      u_cnt = 0;
    end
    cyc++;
  endtask

  task automatic wait_free(input int budget);
    int n = 0;
    while ((m_busy || want_any()) && n < budget) begin step(); n++; end
    check("wait_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_order  = '1;
    bus.u_accepted = 1'b0;
    bus.u_done     = 1'b0;
    #1;
    check("rst_accepted", bus.req_accepted, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_res_rd", bus.res_rd, 0);
    check("rst_res_pa_rd", bus.res_pa_rd, 0);
    check("rst_u_order", bus.u_order, 0);
    check("rst_u_operands", {bus.u_func3, bus.u_func7, bus.u_rs1, bus.u_rs2}, 0);
    check("rst_err", bus.err_spurious, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_order = '0;
  endtask

  initial begin
    int n, v;
    rst = 1'b1;
    bus.req_order = '0; bus.req_func3 = '0; bus.req_func7 = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_pa_rd = '0;
    bus.u_accepted = 1'b0; bus.u_done = 1'b0; bus.u_rd = '0;
    for (int i = 0; i < N; i++) begin
      pf3[i] = '0; pf7[i] = '0; prs1[i] = '0; prs2[i] = '0; ptag[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Contention: both order together, then req0 re-orders against pending req1
    grant_log.delete();
    force_bp = 0; force_lat = 1;
    set_req(0, 3'd7, 7'd1, 32'd100, 32'd7, 6'h0A);
    set_req(1, 3'd5, 7'd1, 32'd90, 32'd9, 6'h0B);
    n = 0;
    while (!m_busy && n < 20) begin step(); n++; end
    while (m_busy && n < 40) begin step(); n++; end
    check("contend_budget", n < 40, 1'b1);
    check("contend_res0", bus.res_rd, 32'd2);
    check("contend_tag0", bus.res_pa_rd, 6'h0A);
    set_req(0, 3'd5, 7'd1, 32'd81, 32'd9, 6'h0C);
    wait_free(60);
    check("grant_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      v = grant_log[0] * 100 + grant_log[1] * 10 + grant_log[2];
`ifdef ALU_EXT_ARB_FIXED_PRIO_EN
      check("grant_order", v, 1);
`else
      check("grant_order", v, 10);
`endif
    end

    // Single DIVU op, unit latency 3 from u_order
    force_bp = 0; force_lat = 2;
    set_req(0, 3'd5, 7'd1, 32'd100, 32'd7, 6'h11);
    wait_free(30);
    check("divu_latency", act_done_cyc - act_acc_cyc, 4);
    check("divu_res", bus.res_rd, 32'd14);
    check("divu_tag", bus.res_pa_rd, 6'h11);

    // Single-cycle unit path
    set_req(1, 3'd0, 7'd0, 32'd5, 32'd6, 6'h22);
    wait_free(30);
    check("single_latency", act_done_cyc - act_acc_cyc, 2);
    check("single_res", bus.res_rd, 32'd0);
    check("single_tag", bus.res_pa_rd, 6'h22);

    // Backpressure for five cycles
    force_bp = 5; force_lat = 1;
    set_req(0, 3'd5, 7'd1, 32'd50, 32'd5, 6'h33);
    wait_free(40);
    check("bp_latency", act_done_cyc - act_acc_cyc, 8);
    check("bp_res", bus.res_rd, 32'd10);

    // Reset while waiting on the unit
    force_bp = 0; force_lat = 6;
    set_req(0, 3'd5, 7'd1, 32'd1000, 32'd3, 6'h2C);
    n = 0;
    while (!(m_busy && !m_issue) && n < 20) begin step(); n++; end
    check("wait_reach", n < 20, 1'b1);
    step();
    do_reset();
    force_bp = -1; force_lat = -1;
    set_req(1, 3'd7, 7'd1, 32'd100, 32'd7, 6'h15);
    wait_free(30);
    check("post_rst_res", bus.res_rd, 32'd2);
    check("post_rst_tag", bus.res_pa_rd, 6'h15);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 2) == 0)
          set_req(i, 3'($urandom_range(0, 7)), 7'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 50)),
                  6'($urandom));
      end
      step();
    end
    wait_free(60);

    // Spurious unit done while idle is sticky
    spur_req = 1;
    repeat (4) step();
    check("spur_sticky", bus.err_spurious, 1'b1);
    do_reset();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_ext_arb.md
ALU_EXT_ARB -- requirements
Module: alu_ext_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one alu_ext unit; legal range 2..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 req_order  input  NUM_REQ  per-requester request strobe.
REQ-005 req_func3 / req_func7  input  NUM_REQ*`LEN_FUNC3 / NUM_REQ*`LEN_FUNC7  packed op selects; slice i belongs to requester i.
REQ-006 req_rs1 / req_rs2  input  NUM_REQ*`LEN_WORD each  packed operands.
REQ-007 req_pa_rd  input  NUM_REQ*`LEN_PREG_ADDR  packed destination physical register tags.
REQ-008 req_accepted  output  NUM_REQ  one-hot one-cycle pulse: request latched.
REQ-009 req_done  output  NUM_REQ  one-hot one-cycle pulse: result valid.
REQ-010 res_rd  output  `LEN_WORD  result word, valid when any req_done bit high.
REQ-011 res_pa_rd  output  `LEN_PREG_ADDR  tag of finished op, valid with req_done.
REQ-012 u_order / u_accepted / u_done  output / input / input  1 each  handshake to alu_ext.
REQ-013 u_func3, u_func7, u_rs1, u_rs2  output  widths as REQ-005/006  operands to alu_ext.
REQ-014 u_rd  input  `LEN_WORD  alu_ext result, valid when u_done high.
REQ-015 err_spurious  output  1  sticky: u_done seen outside ISSUE/WAIT.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, DONE; exactly one active.
REQ-017 IDLE: if any req_order bit high, grant g chosen per REQ-024, req_accepted[g]=1 combinationally this cycle, slice g of func3/func7/rs1/rs2/pa_rd plus g latched at edge, next ISSUE; else stay IDLE, req_accepted=0.
REQ-018 Requester SHALL drop req_order the cycle after its accepted pulse; a held order is treated as a new request at the next IDLE.
REQ-019 ISSUE: u_order=1 driven from latched operands; u_accepted=1 and u_done=1 same cycle -> u_rd captured, next DONE; u_accepted=1 only -> WAIT; u_accepted=0 -> stay ISSUE, operands held.
REQ-020 WAIT: u_order=0; u_done=1 -> u_rd captured, next DONE; no timeout.
REQ-021 DONE: req_done[g]=1 for exactly one cycle, res_rd=captured word, res_pa_rd=latched tag; next IDLE; RR pointer updated.
REQ-022 Latency: order at IDLE cycle t -> accepted t, u_order t+1; unit done at cycle t+k (k>=1) -> req_done at t+k+1.
REQ-023 Throughput: at most one op in flight; req_accepted never asserted outside IDLE; orders arriving in ISSUE/WAIT/DONE wait.
REQ-024 Arbitration: round-robin; search starts at pointer p, first high req_order bit at index p, p+1, ... wraps mod NUM_REQ; after DONE p=(g+1) mod NUM_REQ.
REQ-025 Simultaneous requests: exactly one granted; others remain pending, not accepted.
REQ-026 u_done in IDLE or DONE ignored for data, sets err_spurious; err_spurious cleared only by rst.
REQ-027 res_rd/res_pa_rd hold last values outside DONE; req_done and req_accepted 0 outside their states.

Reset
REQ-028 rst high asynchronously forces IDLE, pointer 0, latched operands/tag/result 0, err_spurious 0, all outputs 0.
REQ-029 rst mid-operation abandons the op: no req_done issued; alu_ext is reset by the same rst.
REQ-030 First grant after rst deassert evaluated on the first rising edge with rst low.

Configuration
REQ-031 ALU_EXT_ARB_FIXED_PRIO_EN defined: lowest-index high req_order always wins, pointer not instantiated; undefined: round-robin per REQ-024.

Verification
REQ-032 Single op: req0 DIVU rs1=100 rs2=7, unit k=3 -> accepted[0] at t, req_done[0] at t+4, res_rd=14, res_pa_rd=req0 tag.
REQ-033 Contention: req0 and req1 both order at t after reset -> req0 served first (res_rd REMU 100%7=2), req1 accepted first IDLE after req0 done; next simultaneous pair -> req1 first (round-robin); with ALU_EXT_ARB_FIXED_PRIO_EN req0 first both times.
REQ-034 Single-cycle unit path: non-divide func3 -> u_accepted and u_done same cycle -> req_done at t+2, res_rd=0.
REQ-035 Backpressure: u_accepted held 0 for 5 cycles -> u_order stays 1, operands stable, no req_done until accept.
REQ-036 Reset in WAIT: rst pulse -> state IDLE, no req_done, all outputs 0; next request processed normally.
REQ-037 Spurious: u_done=1 in IDLE -> err_spurious=1 and remains 1 until rst; no req_done.
